spi_master: RTL and testbench

//   SPI mode-0 master (CPOL=0, CPHA=0), MSB first, single-chip-select; the

---
 rtl/spi_master.sv | 203 ++++++++++++++++++++
 tb/tb_spi_master.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : SPI mode-0 master (CPOL=0, CPHA=0), MSB first, one chip
//               select. Words from a valid/ready source become SCK/MOSI/SSEL
//               frames; the word shifted in on MISO comes back on rx_data.
//               Back-to-back words share one SSEL assertion.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int GAP     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              ssel
);

    // Counter widths hold the largest count value; the +1 keeps a
    // divide-by-one or one-cycle gap at a legal 1-bit width.
    localparam int c_PH_W  = $clog2(CLK_DIV + 1);
    localparam int c_GAP_W = $clog2(GAP + 1);
    localparam int c_BIT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEAD = 3'd1,
        S_HIGH = 3'd2,
        S_LOW  = 3'd3,
        S_GAPW = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [c_PH_W-1:0]   r_phase;
    logic [c_GAP_W-1:0]  r_gap;
    logic [c_BIT_W-1:0]  r_bit;
    logic [DATA_W-2:0]   r_tx_shift;   // bits still to send after the current one
    logic [DATA_W-1:0]   r_rx_shift;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_rx_valid;
    logic                r_sck;
    logic                r_mosi;
    logic                r_ssel;
    logic                r_busy;

    logic                w_phase_done;
    logic                w_gap_done;
    logic                w_last_bit;
    logic                w_tx_ready;
    logic                w_load;       // accept tx_data this cycle
    logic                w_rise;       // this edge raises sck
    logic                w_fall;       // this edge lowers sck
    logic                w_eow;        // end-of-word cycle
    logic                w_in_frame;

    assign w_phase_done = (r_phase == c_PH_W'(CLK_DIV - 1));
    assign w_gap_done   = (r_gap == c_GAP_W'(GAP - 1));
    assign w_last_bit   = (r_bit == c_BIT_W'(DATA_W - 1));
    assign w_in_frame   = (w_next_state == S_LEAD) || (w_next_state == S_HIGH) ||
                          (w_next_state == S_LOW);

    // Next-state decode plus the single-cycle strobes that steer the datapath.
    always_comb begin
        w_next_state = r_state;
        w_tx_ready   = 1'b0;
        w_load       = 1'b0;
        w_rise       = 1'b0;
        w_fall       = 1'b0;
        w_eow        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_ready = 1'b1;
                if (tx_valid) begin
                    w_load       = 1'b1;
                    w_next_state = S_LEAD;
                end
            end
            S_LEAD: begin
                if (w_phase_done) begin
                    w_rise       = 1'b1;
                    w_next_state = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_phase_done) begin
                    w_fall       = 1'b1;
                    w_next_state = S_LOW;
                end
            end
            S_LOW: begin
                if (w_phase_done) begin
                    if (w_last_bit) begin
                        // Word complete: hand back rx and offer a burst slot.
                        w_eow      = 1'b1;
                        w_tx_ready = 1'b1;
                        if (tx_valid) begin
                            w_load       = 1'b1;
                            w_next_state = S_LEAD;
                        end else begin
                            w_next_state = S_GAPW;
                        end
                    end else begin
                        w_rise       = 1'b1;
                        w_next_state = S_HIGH;
                    end
                end
            end
            S_GAPW: begin
                if (w_gap_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register and the phase, gap and bit counters (reload on change).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_gap   <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_phase <= '0;
            end else if (r_state != S_IDLE && r_state != S_GAPW) begin
                r_phase <= r_phase + c_PH_W'(1);
            end
            if (r_state == S_GAPW && w_next_state == S_GAPW) begin
                r_gap <= r_gap + c_GAP_W'(1);
            end else begin
                r_gap <= '0;
            end
            if (w_load) begin
                r_bit <= '0;
            end else if (w_rise && r_state == S_LOW) begin
                r_bit <= r_bit + c_BIT_W'(1);
            end
        end
    end

    // Shift registers: MOSI advances as sck falls, MISO is taken as sck rises.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            r_rx_valid <= w_eow;
            if (w_eow) begin
                r_rx_data <= r_rx_shift;
            end
            if (w_load) begin
                r_mosi     <= tx_data[DATA_W-1];
                r_tx_shift <= tx_data[DATA_W-2:0];
            end else if (w_fall) begin
                r_mosi     <= r_tx_shift[DATA_W-2];
                r_tx_shift <= r_tx_shift << 1;
            end
            if (w_rise) begin
                r_rx_shift <= {r_rx_shift[DATA_W-2:0], miso};
            end
        end
    end

    // Pin outputs registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sck  <= 1'b0;
            r_ssel <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_sck  <= (w_next_state == S_HIGH);
            r_ssel <= !w_in_frame;
            r_busy <= (w_next_state != S_IDLE);
        end
    end

    assign tx_ready = w_tx_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;
    assign sck      = r_sck;
    assign mosi     = r_mosi;
    assign ssel     = r_ssel;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master
// Description : Self-checking bench for spi_master: vector table, random
//               frames against a reference model, and hand-built corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    localparam int DW    = 8;
    localparam int DIV   = 4;
    localparam int GP    = 4;
    localparam int FRAME = (2 * DW + 1) * DIV;   // ssel-low cycles per single word

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, busy, sck, mosi, miso, ssel;

    logic [7:0] tx_data_b;
    logic       tx_valid_b;
    logic       tx_ready_b;
    logic [7:0] rx_data_b;
    logic       rx_valid_b, busy_b, sck_b, mosi_b, miso_b, ssel_b;

    spi_master #(.DATA_W(DW), .CLK_DIV(DIV), .GAP(GP)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .sck(sck), .mosi(mosi), .miso(miso), .ssel(ssel)
    );

    spi_master #(.DATA_W(DW), .CLK_DIV(1), .GAP(1)) dut_b (
        .clk(clk), .reset(reset), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .busy(busy_b),
        .sck(sck_b), .mosi(mosi_b), .miso(miso_b), .ssel(ssel_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- mode-0 slave model (or loopback) ----------------
    logic       loopback = 1'b1;
    logic [7:0] slv_word = 8'h00;
    logic [7:0] slv_rx   = 8'h00;
    logic       slv_miso = 1'b0;
    logic       slv_psck = 1'b0;
    int         slv_cnt  = 0;

    assign miso   = loopback ? mosi : slv_miso;
    assign miso_b = mosi_b;

    always @(ssel or sck or slv_word) begin
        if (ssel !== 1'b0) begin
            slv_cnt  = 0;
            slv_miso = slv_word[7];
        end else if (sck === 1'b1 && slv_psck === 1'b0) begin
            slv_rx  = {slv_rx[6:0], mosi};
            slv_cnt = slv_cnt + 1;
        end else if (sck === 1'b0 && slv_psck === 1'b1) begin
            slv_miso = slv_word[7 - (slv_cnt % 8)];
        end
        slv_psck = sck;
    end

    // ---------------- bus monitor for the main DUT ----------------
    int         rx_count = 0;
    logic [7:0] rx_log [512];
    int         rise_total = 0, mosi_viol = 0, sck_viol = 0;
    int         low_run = 0, last_low_len = 0, high_run = 0, last_high_len = 0;
    logic       p_sck = 1'b0, p_mosi = 1'b0, p_ssel = 1'b1;

    always begin
        @(posedge clk);
        #1;
        if (rx_valid === 1'b1) begin
            rx_log[rx_count[8:0]] = rx_data;
            rx_count++;
        end
        if (sck === 1'b1 && p_sck === 1'b0) rise_total++;
        if (sck === 1'b1 && p_sck === 1'b1 && mosi !== p_mosi) mosi_viol++;
        if (ssel === 1'b1 && sck === 1'b1) sck_viol++;
        if (ssel === 1'b0) low_run++;
        if (ssel === 1'b1 && p_ssel === 1'b0) begin
            last_low_len = low_run;
            low_run = 0;
        end
        if (ssel === 1'b1) high_run++;
        if (ssel === 1'b0 && p_ssel === 1'b1) begin
            last_high_len = high_run;
            high_run = 0;
        end
        p_sck  = sck;
        p_mosi = mosi;
        p_ssel = ssel;
    end

    // ---------------- monitor for the divide-by-one DUT ----------------
    int         rx_count_b = 0;
    logic [7:0] rx_log_b [16];
    int         rise_b = 0, per2_b = 0, per3_b = 0, per_other_b = 0;
    int         cyc_b = 0, last_rise_b = -1;
    logic       p_sck_b = 1'b0;

    always begin
        @(posedge clk);
        #1;
        cyc_b++;
        if (rx_valid_b === 1'b1) begin
            rx_log_b[rx_count_b[3:0]] = rx_data_b;
            rx_count_b++;
        end
        if (ssel_b !== 1'b0) begin
            last_rise_b = -1;
        end else if (sck_b === 1'b1 && p_sck_b === 1'b0) begin
            rise_b++;
            if (last_rise_b >= 0) begin
                case (cyc_b - last_rise_b)
                    2:       per2_b++;
                    3:       per3_b++;
                    default: per_other_b++;
                endcase
            end
            last_rise_b = cyc_b;
        end
        p_sck_b = sck_b;
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_rx(input logic lb, input logic [7:0] tx, input logic [7:0] slv);
        return lb ? tx : slv;
    endfunction

    // ---------------- helpers ----------------
    task automatic wait_rx(input int target, input string tag);
        int g;
        g = 0;
        while (rx_count < target && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_rx_wait"}, 32'(rx_count >= target), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int g;
        g = 0;
        while (busy !== 1'b0 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_idle_wait"}, 32'(busy), 32'd0);
    endtask

    task automatic send_one(input logic [7:0] w, input logic [7:0] s, input logic lb,
                            input logic [7:0] exp_rx, input logic [7:0] exp_cap, input string tag);
        int n0, r0, g;
        n0 = rx_count;
        r0 = rise_total;
        loopback = lb;
        slv_word = s;
        @(negedge clk);
        tx_data  = w;
        tx_valid = 1'b1;
        g = 0;
        while (tx_ready !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_accept"}, 32'(tx_ready), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_rx(n0 + 1, tag);
        wait_idle(tag);
        chk({tag, "_rx_data"}, 32'(rx_log[n0[8:0]]), 32'(exp_rx));
        chk({tag, "_pulses"}, 32'(rx_count - n0), 32'd1);
        chk({tag, "_slave_cap"}, 32'(slv_rx), 32'(exp_cap));
        chk({tag, "_ssel_low"}, 32'(last_low_len), 32'(FRAME));
        chk({tag, "_sck_rises"}, 32'(rise_total - r0), 32'(DW));
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] slv;
        logic       lb;
        logic [7:0] exp_rx;
        logic [7:0] exp_cap;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0, r0, acc, g, hi;

        vecs[0] = '{8'h2A, 8'h00, 1'b1, 8'h2A, 8'h2A};
        vecs[1] = '{8'h3C, 8'hA5, 1'b0, 8'hA5, 8'h3C};
        vecs[2] = '{8'h00, 8'hFF, 1'b0, 8'hFF, 8'h00};
        vecs[3] = '{8'hFF, 8'h00, 1'b0, 8'h00, 8'hFF};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h01, 8'h80};
        vecs[5] = '{8'h01, 8'h80, 1'b1, 8'h01, 8'h01};

        reset      = 1'b0;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        tx_data_b  = 8'h00;
        tx_valid_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", 32'({sck, ssel, mosi, rx_valid, busy, tx_ready, rx_data}),
            32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00}));
        chk("reset_state_b", 32'({sck_b, ssel_b, mosi_b, rx_valid_b, busy_b, tx_ready_b, rx_data_b}),
            32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00}));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Vector table: loopback and slave-model words, including tests 1 and 2.
        for (int i = 0; i < 6; i++) begin
            send_one(vecs[i].tx, vecs[i].slv, vecs[i].lb, vecs[i].exp_rx, vecs[i].exp_cap, "vec");
        end

        // Random single frames against the reference model.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] w, s;
            logic       lb;
            w  = 8'($urandom_range(0, 255));
            s  = 8'($urandom);
            lb = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send_one(w, s, lb, model_rx(lb, w, s), w, "rnd");
        end

        // Burst of 42,43,44 with tx_valid held; ssel must stay low throughout.
        n0 = rx_count;
        r0 = rise_total;
        loopback = 1'b1;
        @(negedge clk);
        tx_data  = 8'd42;
        tx_valid = 1'b1;
        acc = 0;
        g   = 0;
        while (acc < 3 && g < 2000) begin
            if (tx_ready === 1'b1) begin
                acc++;
                @(negedge clk);
                if (acc < 3) tx_data = tx_data + 8'd1;
                else         tx_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
            g++;
        end
        tx_valid = 1'b0;
        chk("burst_accepts", 32'(acc), 32'd3);
        wait_rx(n0 + 3, "burst");
        chk("burst_pulses", 32'(rx_count - n0), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk("burst_rx", 32'(rx_log[9'(n0 + k)]), 32'(42 + k));
        end
        chk("burst_ssel_low", 32'(last_low_len), 32'(3 * FRAME));
        chk("burst_sck_rises", 32'(rise_total - r0), 32'(3 * DW));

        // ssel just rose: a word offered now must wait out the gap.
        chk("gap_ssel_high", 32'(ssel), 32'd1);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        hi = 0;
        for (int k = 0; k < GP; k++) begin
            if (tx_ready !== 1'b0) hi++;
            @(negedge clk);
        end
        chk("gap_ready_low", 32'(hi), 32'd0);
        chk("gap_ready_after", 32'(tx_ready), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_rx(n0 + 4, "gap");
        wait_idle("gap");
        chk("gap_rx", 32'(rx_log[9'(n0 + 3)]), 32'h5A);
        chk("gap_ssel_high_len", 32'(last_high_len), 32'(GP + 1));

        // Reset during bit 3 aborts the frame with no rx_valid.
        n0 = rx_count;
        r0 = rise_total;
        loopback = 1'b1;
        @(negedge clk);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        g = 0;
        while (tx_ready !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        g = 0;
        while (rise_total - r0 < 4 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("abort_reach_bit3", 32'(rise_total - r0), 32'd4);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_outputs", 32'({sck, ssel, mosi, busy, rx_valid}), 32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_rx", 32'(rx_count - n0), 32'd0);
        send_one(8'h81, 8'h00, 1'b1, 8'h81, 8'h81, "after_abort");

        // Divide-by-one instance: burst of 0xFF then 0x00 in loopback.
        @(negedge clk);
        tx_data_b  = 8'hFF;
        tx_valid_b = 1'b1;
        acc = 0;
        g   = 0;
        while (acc < 2 && g < 500) begin
            if (tx_ready_b === 1'b1) begin
                acc++;
                @(negedge clk);
                if (acc < 2) tx_data_b = 8'h00;
                else         tx_valid_b = 1'b0;
            end else begin
                @(negedge clk);
            end
            g++;
        end
        tx_valid_b = 1'b0;
        chk("div1_accepts", 32'(acc), 32'd2);
        g = 0;
        while ((rx_count_b < 2 || busy_b !== 1'b0) && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("div1_pulses", 32'(rx_count_b), 32'd2);
        chk("div1_rx0", 32'(rx_log_b[0]), 32'hFF);
        chk("div1_rx1", 32'(rx_log_b[1]), 32'h00);
        chk("div1_rises", 32'(rise_b), 32'd16);
        chk("div1_period2", 32'(per2_b), 32'd14);
        chk("div1_burst_lead", 32'(per3_b), 32'd1);
        chk("div1_other_period", 32'(per_other_b), 32'd0);

        chk("mosi_stable_sck_high", 32'(mosi_viol), 32'd0);
        chk("sck_low_when_idle", 32'(sck_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
